// File: rtl/nn_pkg.sv
// ============================================================================
// nn_pkg : phase constants, sample type and argmax helper for layer_sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

  localparam int PH_CAPTURE     = 0;
  localparam int PH_LOAD        = 1;
  localparam int PASS_LEN_DEF   = 7;
  localparam int DATA_WIDTH_DEF = 8;

  // Widest vector the argmax helper accepts; callers zero-extend into it.
  localparam int NN_MAX_DW  = 32;
  localparam int NN_MAX_OUT = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

  function automatic logic signed [NN_MAX_DW-1:0] elem_sext(
    input logic [NN_MAX_OUT*NN_MAX_DW-1:0] y,
    input int                              j,
    input int                              dw
  );
    logic [NN_MAX_DW-1:0] r;
    for (int b = 0; b < NN_MAX_DW; b++) begin
      r[b] = (b < dw) ? y[j*dw + b] : y[j*dw + dw - 1];
    end
    return $signed(r);
  endfunction

  // Strict greater-than keeps the lowest index on ties.
  function automatic int unsigned argmax_idx(
    input logic [NN_MAX_OUT*NN_MAX_DW-1:0] y,
    input int                              num_out,
    input int                              dw
  );
    logic signed [NN_MAX_DW-1:0] best;
    logic signed [NN_MAX_DW-1:0] cur;
    int unsigned                 idx;
    best = elem_sext(y, 0, dw);
    idx  = 0;
    for (int j = 1; j < NN_MAX_OUT; j++) begin
      cur = elem_sext(y, j, dw);
      if ((j < num_out) && (cur > best)) begin
        best = cur;
        idx  = j;
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_sequencer_if.sv
// ============================================================================
// layer_sequencer_if : input/neuron/output handshake bundle of layer_sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface layer_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 3,
  parameter int CLS_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_IN*DATA_WIDTH-1:0]  in_data;
  logic                          nrn_en;
  logic                          nrn_run;
  logic [NUM_IN*DATA_WIDTH-1:0]  nrn_x;
  logic [NUM_OUT*DATA_WIDTH-1:0] nrn_y;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_data;
  logic [CLS_W-1:0]              out_class;
  logic                          busy;

  modport master (
    input  in_valid, in_data, nrn_y, out_ready,
    output in_ready, nrn_en, nrn_run, nrn_x, out_valid, out_data, out_class, busy
  );

  modport slave (
    output in_valid, in_data, nrn_y, out_ready,
    input  in_ready, nrn_en, nrn_run, nrn_x, out_valid, out_data, out_class, busy
  );

endinterface

`default_nettype wire

// File: rtl/layer_sequencer_result_fifo.sv
// ============================================================================
// result_fifo : 2-entry output FIFO; head entry is always presented on dout_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // pop_i is only asserted when non-empty, push_i only when not full.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  assign dout_o  = head_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// layer_sequencer : feeds one free-running neuron layer and buffers its results
// Optional feature macro: ARGMAX_EN (stores/presents argmax class per result)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 3,
  parameter int PASS_LEN   = PASS_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  layer_sequencer_if.master bus
);

  localparam int PH_W  = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
  localparam int XW    = NUM_IN * DATA_WIDTH;
  localparam int YW    = NUM_OUT * DATA_WIDTH;
  localparam int CLS_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
`ifdef ARGMAX_EN
  localparam int FW    = YW + CLS_W;
`else
  localparam int FW    = YW;
`endif

  logic [PH_W-1:0] ph_q, ph_d;
  logic            tag_q, tag_d;
  logic            boot_q, boot_d;
  logic [XW-1:0]   nrn_x_q, nrn_x_d;

  logic            w_at_cap;
  logic            w_wrap;
  logic            w_push;
  logic            w_pop;
  logic            w_in_ready;
  logic            w_accept;
  logic [1:0]      w_count;
  logic [1:0]      w_count_nxt;
  logic [FW-1:0]   w_fifo_din;
  logic [FW-1:0]   w_fifo_dout;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q    <= '0;
      tag_q   <= 1'b0;
      boot_q  <= 1'b1;
      nrn_x_q <= '0;
    end else begin
      ph_q    <= ph_d;
      tag_q   <= tag_d;
      boot_q  <= boot_d;
      nrn_x_q <= nrn_x_d;
    end
  end

  // Next-state logic; boot_q marks the neuron BYPASS pass, which never loads X.
  always_comb begin
    ph_d    = w_wrap ? '0 : ph_q + 1'b1;
    boot_d  = boot_q && !w_wrap;
    tag_d   = tag_q;
    nrn_x_d = nrn_x_q;
    if (w_at_cap) tag_d = w_accept;
    if (w_accept) nrn_x_d = bus.in_data;
  end

  // Output / handshake logic
  always_comb begin
    w_at_cap    = (ph_q == PH_W'(PH_CAPTURE));
    w_wrap      = (ph_q == PH_W'(PASS_LEN - 1));
    w_push      = w_at_cap && tag_q;
    w_pop       = bus.out_ready && (w_count != 2'd0);
    w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};
    w_in_ready  = w_at_cap && !boot_q && (w_count_nxt <= 2'd1);
    w_accept    = bus.in_valid && w_in_ready;
  end

`ifdef ARGMAX_EN
  logic [CLS_W-1:0] w_cls;
  assign w_cls = CLS_W'(argmax_idx((NN_MAX_OUT*NN_MAX_DW)'(bus.nrn_y), NUM_OUT, DATA_WIDTH));
  assign w_fifo_din    = {w_cls, bus.nrn_y};
  assign bus.out_class = w_fifo_dout[FW-1 -: CLS_W];
`else
  assign w_fifo_din    = bus.nrn_y;
  assign bus.out_class = '0;
`endif

  result_fifo #(
    .W (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_fifo_din),
    .dout_o  (w_fifo_dout),
    .count_o (w_count)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.nrn_en    = 1'b1;
  assign bus.nrn_run   = 1'b1;
  assign bus.nrn_x     = nrn_x_q;
  assign bus.out_valid = (w_count != 2'd0);
  assign bus.out_data  = w_fifo_dout[YW-1:0];
  assign bus.busy      = tag_q || (w_count != 2'd0);

endmodule

`default_nettype wire
